// File: rtl/nonogram_render.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : nonogram_render
//  Purpose  : Loads NxN nonogram clues/solution over valid/ready streams and
//             renders clues, grid lines and tiles as a 2-cycle RGB444 stream.
//  Revision : 1.0 - initial release
// ============================================================================
module nonogram_render #(
    parameter int N    = 10,
    parameter int K    = 5,
    parameter int CW   = 4,
    parameter int CELL = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              load_start_i,
    input  logic              solver_done_i,
    input  logic              clue_valid_i,
    output logic              clue_ready_o,
    input  logic [K*CW-1:0]   clue_data_i,
    input  logic              grid_valid_i,
    output logic              grid_ready_o,
    input  logic [N-1:0]      grid_data_i,
    input  logic              show_solution_i,
    input  logic [12:0]       hcount_i,
    input  logic [12:0]       vcount_i,
    output logic [11:0]       pixel_out_o,
    output logic              clues_loaded_o,
    output logic              grid_loaded_o,
    output logic              busy_o
);

    localparam int LB  = $clog2(CELL);
    localparam int SS  = LB - 3;
    localparam int RW  = $clog2(N);
    localparam int CIW = $clog2(2 * N);
    localparam int JW  = (K > 1) ? $clog2(K) : 1;

    localparam logic [12:0]    OFF_PX    = 13'(K * CELL);
    localparam logic [12:0]    END_PX    = 13'((K + N) * CELL);
    localparam logic [12:0]    KC        = 13'(K);
    localparam logic [CIW-1:0] LAST_CLUE = CIW'(2 * N - 1);
    localparam logic [CIW-1:0] LAST_ROW  = CIW'(N - 1);
    localparam logic [11:0]    C_BLACK   = 12'h000;
    localparam logic [11:0]    C_WHITE   = 12'hFFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLUES = 2'd1;
    localparam logic [1:0] S_GRID  = 2'd2;

    localparam logic [2:0] R_WHITE = 3'd0;
    localparam logic [2:0] R_LINE  = 3'd1;
    localparam logic [2:0] R_CELL  = 3'd2;
    localparam logic [2:0] R_TOP   = 3'd3;
    localparam logic [2:0] R_LEFT  = 3'd4;

    logic [1:0]      state_q, state_d;
    logic [CIW-1:0]  cnt_q;
    logic            clues_loaded_q, grid_loaded_q;
    logic [K*CW-1:0] clue_mem_q [2*N];
    logic [N-1:0]    grid_mem_q [N];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start_i)       state_d = S_CLUES;
                else if (solver_done_i) state_d = S_GRID;
            end
            S_CLUES: if (clue_valid_i && cnt_q == LAST_CLUE) state_d = S_IDLE;
            S_GRID:  if (grid_valid_i && cnt_q == LAST_ROW)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clue_ready_o = (state_q == S_CLUES);
        grid_ready_o = (state_q == S_GRID);
        busy_o       = (state_q != S_IDLE);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q          <= '0;
            clues_loaded_q <= 1'b0;
            grid_loaded_q  <= 1'b0;
            for (int i = 0; i < 2 * N; i++) clue_mem_q[i] <= '0;
            for (int i = 0; i < N; i++)     grid_mem_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start_i) begin
                        cnt_q          <= '0;
                        clues_loaded_q <= 1'b0;
                    end else if (solver_done_i) begin
                        cnt_q         <= '0;
                        grid_loaded_q <= 1'b0;
                    end
                end
                S_CLUES: if (clue_valid_i) begin
                    clue_mem_q[cnt_q] <= clue_data_i;
                    cnt_q             <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CLUE) clues_loaded_q <= 1'b1;
                end
                S_GRID: if (grid_valid_i) begin
                    grid_mem_q[cnt_q[RW-1:0]] <= grid_data_i;
                    cnt_q                     <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ROW) grid_loaded_q <= 1'b1;
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign clues_loaded_o = clues_loaded_q;
    assign grid_loaded_o  = grid_loaded_q;

    // Stage 1: geometry, region classification and memory reads
    logic [12:0]     w_cx, w_cy;
    logic [LB-1:0]   w_lx, w_ly;
    logic [2:0]      w_gcs, w_grs;
    logic [RW-1:0]   w_grow, w_gcol;
    logic [CIW-1:0]  w_cidx;
    logic [JW-1:0]   w_j;
    logic [K*CW-1:0] w_word;
    logic [CW-1:0]   w_field;

    logic [2:0] s1_region_q, s1_region_d;
    logic       s1_fill_q, s1_show_q, s1_gload_q, s1_cload_q, s1_in_q, s1_in_d;
    logic [3:0] s1_v_q;
    logic [2:0] s1_gr_q, s1_gc_q;

    assign w_cx  = hcount_i >> LB;
    assign w_cy  = vcount_i >> LB;
    assign w_lx  = hcount_i[LB-1:0];
    assign w_ly  = vcount_i[LB-1:0];
    assign w_gcs = w_lx[LB-1:SS];
    assign w_grs = w_ly[LB-1:SS];

    always_comb begin
        if (hcount_i > END_PX || vcount_i > END_PX || (hcount_i < OFF_PX && vcount_i < OFF_PX))
            s1_region_d = R_WHITE;
        else if (w_lx == '0 || w_ly == '0)
            s1_region_d = R_LINE;
        else if (w_cx >= KC && w_cy >= KC)
            s1_region_d = R_CELL;
        else if (w_cy < KC)
            s1_region_d = R_TOP;
        else
            s1_region_d = R_LEFT;
    end

    // Index arithmetic is done modulo the index width; it is only meaningful inside its region
    always_comb begin
        w_grow = '0;
        w_gcol = '0;
        w_cidx = '0;
        w_j    = '0;
        case (s1_region_d)
            R_CELL: begin
                w_grow = w_cy[RW-1:0] - RW'(K);
                w_gcol = w_cx[RW-1:0] - RW'(K);
            end
            R_TOP: begin
                w_cidx = w_cx[CIW-1:0] - CIW'(K);
                w_j    = JW'(K - 1) - w_cy[JW-1:0];
            end
            R_LEFT: begin
                w_cidx = CIW'(N) + w_cy[CIW-1:0] - CIW'(K);
                w_j    = JW'(K - 1) - w_cx[JW-1:0];
            end
            default: w_j = '0;
        endcase
    end

    assign w_word  = clue_mem_q[w_cidx];
    assign w_field = w_word[w_j*CW +: CW];
    assign s1_in_d = (w_gcs >= 3'd1) && (w_gcs <= 3'd5) && (w_grs >= 3'd1);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            s1_region_q <= R_WHITE;
            s1_fill_q   <= 1'b0;
            s1_show_q   <= 1'b0;
            s1_gload_q  <= 1'b0;
            s1_cload_q  <= 1'b0;
            s1_in_q     <= 1'b0;
            s1_v_q      <= '0;
            s1_gr_q     <= '0;
            s1_gc_q     <= '0;
        end else begin
            s1_region_q <= s1_region_d;
            s1_fill_q   <= grid_mem_q[w_grow][w_gcol];
            s1_show_q   <= show_solution_i;
            s1_gload_q  <= grid_loaded_q;
            s1_cload_q  <= clues_loaded_q;
            s1_in_q     <= s1_in_d;
            s1_v_q      <= 4'(w_field);
            s1_gr_q     <= w_grs - 3'd1;
            s1_gc_q     <= w_gcs - 3'd1;
        end
    end

    // 5x7 glyphs, row 0 in the top bits, leftmost column is the row MSB
    function automatic logic [34:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 35'b01110_10001_10011_10101_11001_10001_01110;
            4'h1:    glyph = 35'b00100_01100_00100_00100_00100_00100_01110;
            4'h2:    glyph = 35'b01110_10001_00001_00010_00100_01000_11111;
            4'h3:    glyph = 35'b01110_10001_00001_00110_00001_10001_01110;
            4'h4:    glyph = 35'b00010_00110_01010_10010_11111_00010_00010;
            4'h5:    glyph = 35'b11111_10000_11110_00001_00001_10001_01110;
            4'h6:    glyph = 35'b00110_01000_10000_11110_10001_10001_01110;
            4'h7:    glyph = 35'b11111_00001_00010_00100_01000_01000_01000;
            4'h8:    glyph = 35'b01110_10001_10001_01110_10001_10001_01110;
            4'h9:    glyph = 35'b01110_10001_10001_01111_00001_00010_01100;
            4'hA:    glyph = 35'b01110_10001_10001_11111_10001_10001_10001;
            4'hB:    glyph = 35'b11110_10001_10001_11110_10001_10001_11110;
            4'hC:    glyph = 35'b01110_10001_10000_10000_10000_10001_01110;
            4'hD:    glyph = 35'b11110_10001_10001_10001_10001_10001_11110;
            4'hE:    glyph = 35'b11111_10000_10000_11110_10000_10000_11111;
            default: glyph = 35'b11111_10000_10000_11110_10000_10000_10000;
        endcase
    endfunction

    logic [34:0] w_glyph;
    logic [5:0]  w_gidx;
    logic        w_font;
    logic [11:0] pixel_d, pixel_q;

    assign w_glyph = glyph(s1_v_q);
    assign w_gidx  = 6'd34 - 6'd5 * {3'b000, s1_gr_q} - {3'b000, s1_gc_q};
    assign w_font  = w_glyph[w_gidx];

    always_comb begin
        pixel_d = C_WHITE;
        case (s1_region_q)
            R_LINE: pixel_d = C_BLACK;
            R_CELL: pixel_d = (s1_show_q && s1_gload_q && s1_fill_q) ? C_BLACK : C_WHITE;
            R_TOP, R_LEFT:
                pixel_d = (s1_cload_q && s1_v_q != 4'h0 && s1_in_q && w_font) ? C_BLACK : C_WHITE;
            default: pixel_d = C_WHITE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) pixel_q <= C_WHITE;
        else         pixel_q <= pixel_d;
    end

    assign pixel_out_o = pixel_q;

endmodule
`default_nettype wire

// File: tb/tb_nonogram_render.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_nonogram_render
//  Purpose  : Directed scoreboard bench for nonogram_render (N=10, K=5, CELL=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nonogram_render;

    localparam int N = 10;
    localparam int K = 5;
    localparam int CW = 4;
    localparam int CELL = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            load_start = 1'b0, solver_done = 1'b0;
    logic            clue_valid = 1'b0, grid_valid = 1'b0;
    logic            clue_ready, grid_ready;
    logic [K*CW-1:0] clue_data = '0;
    logic [N-1:0]    grid_data = '0;
    logic            show_solution = 1'b0;
    logic [12:0]     hcount = '0, vcount = '0;
    logic [11:0]     pixel_out;
    logic            clues_loaded, grid_loaded, busy;

    always #5 clk = ~clk;

    nonogram_render #(.N(N), .K(K), .CW(CW), .CELL(CELL)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .load_start_i   (load_start),
        .solver_done_i  (solver_done),
        .clue_valid_i   (clue_valid),
        .clue_ready_o   (clue_ready),
        .clue_data_i    (clue_data),
        .grid_valid_i   (grid_valid),
        .grid_ready_o   (grid_ready),
        .grid_data_i    (grid_data),
        .show_solution_i(show_solution),
        .hcount_i       (hcount),
        .vcount_i       (vcount),
        .pixel_out_o    (pixel_out),
        .clues_loaded_o (clues_loaded),
        .grid_loaded_o  (grid_loaded),
        .busy_o         (busy)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          hs = 0;
    logic [11:0] exp_q [$];
    string       nm_q [$];
    logic        probe = 1'b0, p1 = 1'b0, p2 = 1'b0;
    logic [11:0] m_exp;
    string       m_nm;

    always @(posedge clk) begin
        p1 <= probe;
        p2 <= p1;
        if (clue_valid && clue_ready) hs <= hs + 1;
    end

    // Monitor: every pixel tagged at issue emerges two clocks later
    always @(negedge clk) begin
        if (p2) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pixel: pixel_out=%h with empty scoreboard", pixel_out);
            end else begin
                m_exp = exp_q.pop_front();
                m_nm  = nm_q.pop_front();
                if (pixel_out !== m_exp) begin
                    n_bad++;
                    $display("FAIL %s: pixel_out=%h expected %h", m_nm, pixel_out, m_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] e, input string nm);
        hcount = 13'(h);
        vcount = 13'(v);
        probe  = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        tick();
        probe = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    // Beat 0 = column 0 top clues {.., A, 3}; beat 10 = row 0 left clues {.., 5}
    function automatic logic [K*CW-1:0] beat_data(input int b);
        if (b == 0)       return 20'h000A3;
        else if (b == 10) return 20'h00005;
        else              return 20'(b & 15);
    endfunction

    // Feeds clue beats with valid toggling 1/0 until 20 handshakes or budget runs out
    task automatic feed_clues(input int h0);
        for (int c = 0; c < 200 && (hs - h0) < 2 * N; c++) begin
            clue_valid = (c % 2 == 0);
            clue_data  = beat_data(hs - h0);
            if (c == 4) chk("clues_loaded_during_load", 32'(clues_loaded), 32'd0);
            tick();
        end
        clue_valid = 1'b0;
        chk("handshakes", 32'(hs - h0), 32'd20);
        chk("clues_loaded_after_last", 32'(clues_loaded), 32'd1);
        chk("busy_after_clues", 32'(busy), 32'd0);
        clue_valid = 1'b1;
        repeat (3) tick();
        clue_valid = 1'b0;
        chk("no_extra_handshake", 32'(hs - h0), 32'd20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int r;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clue_ready", 32'(clue_ready), 32'd0);
        chk("rst_grid_ready", 32'(grid_ready), 32'd0);
        chk("rst_clues_loaded", 32'(clues_loaded), 32'd0);
        chk("rst_grid_loaded", 32'(grid_loaded), 32'd0);
        chk("rst_pixel", 32'(pixel_out), 32'hFFF);
        @(negedge clk) rst = 1'b0;
        tick();

        // Reset in the middle of a clue load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("busy_in_clues", 32'(busy), 32'd1);
        for (int c = 0; c < 7; c++) begin
            clue_valid = 1'b1;
            clue_data  = beat_data(c);
            tick();
        end
        clue_valid = 1'b1;
        clue_data  = beat_data(7);
        #2 rst = 1'b1;
        #1;
        chk("midrst_clue_ready", 32'(clue_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_clues_loaded", 32'(clues_loaded), 32'd0);
        clue_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        tick();
        pix(90, 68, 12'hFFF, "midrst_top_glyph");
        pix(84, 50, 12'hFFF, "midrst_top_glyph2");
        drain();

        // Full clue load with toggling valid
        h0 = hs;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("clue_ready_in_clues", 32'(clue_ready), 32'd1);
        feed_clues(h0);

        pix(88, 68, 12'hFFF, "top3_gc3_gr1");
        pix(90, 68, 12'h000, "top3_gc4_gr1");
        pix(84, 66, 12'h000, "top3_gc1_gr0");
        pix(80, 70, 12'h000, "gridline_x80");
        pix(84, 50, 12'h000, "topA_gc1_gr0");
        pix(82, 50, 12'hFFF, "topA_gc0_gr0");
        pix(94, 68, 12'hFFF, "top_out_of_glyph");
        pix(88, 36, 12'hFFF, "top_blank_field");
        pix(66, 82, 12'h000, "left5_gc0_gr0");
        pix(66, 86, 12'h000, "left5_gc0_gr2");
        pix(74, 86, 12'hFFF, "left5_gc4_gr2");
        drain();

        // Solution load: only row 0 column 0 filled
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        chk("grid_ready_in_grid", 32'(grid_ready), 32'd1);
        chk("grid_loaded_cleared", 32'(grid_loaded), 32'd0);
        r = 0;
        for (int c = 0; c < 50 && r < N; c++) begin
            grid_valid = 1'b1;
            grid_data  = (r == 0) ? 10'b0000000001 : 10'b0;
            if (grid_ready) r++;
            tick();
        end
        grid_valid = 1'b0;
        chk("grid_loaded_after_last", 32'(grid_loaded), 32'd1);
        chk("grid_ready_after_last", 32'(grid_ready), 32'd0);

        show_solution = 1'b1;
        pix(88, 88, 12'h000, "cell_r0c0_filled");
        pix(104, 88, 12'hFFF, "cell_r0c1_empty");
        pix(88, 104, 12'hFFF, "cell_r1c0_empty");
        show_solution = 1'b0;
        pix(88, 88, 12'hFFF, "cell_r0c0_hidden");
        drain();

        // load_start wins over solver_done; solver_done ignored while busy
        h0 = hs;
        load_start  = 1'b1;
        solver_done = 1'b1;
        tick();
        load_start  = 1'b0;
        solver_done = 1'b0;
        chk("both_clue_ready", 32'(clue_ready), 32'd1);
        chk("both_grid_ready", 32'(grid_ready), 32'd0);
        solver_done = 1'b1;
        tick();
        solver_done = 1'b0;
        chk("done_in_clues_grid_ready", 32'(grid_ready), 32'd0);
        chk("done_in_clues_clue_ready", 32'(clue_ready), 32'd1);
        feed_clues(h0);
        chk("grid_loaded_kept", 32'(grid_loaded), 32'd1);
        chk("grid_ready_idle", 32'(grid_ready), 32'd0);

        show_solution = 1'b1;
        pix(88, 88, 12'h000, "cell_r0c0_after_reload");
        pix(90, 68, 12'h000, "top3_after_reload");
        pix(40, 40, 12'hFFF, "corner_40_40");
        pix(300, 10, 12'hFFF, "far_300_10");
        pix(241, 100, 12'hFFF, "past_right_241");
        pix(240, 100, 12'h000, "right_edge_240");
        pix(100, 240, 12'h000, "bottom_edge_240");
        drain();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
